axi4_lite_rd: RTL and testbench

//  AXI4-Lite read initiator: converts a single-beat user read request into AR/R channel

---
 rtl/axi4_lite_rd_if.sv | 24 ++
 rtl/axi4_lite_rd.sv | 157 +++++++++++++++
 tb/tb_axi4_lite_rd.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_rd_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the read initiator and its slave.
interface axi4_lite_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [2:0]        s_axi_arprot;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi4_lite_rd.sv
// AXI4-Lite single-beat read initiator: one user request -> one AR/R transaction.
// Optional abort of a hung slave when AXI4_LITE_RD_TIMEOUT_EN is defined.
module axi4_lite_rd #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic              rd_timeout,
  output logic              rd_dvalid,
  input  logic              rd_dready,
  axi4_lite_rd_if.master    s_axi
);

  typedef enum logic [3:0] {
    SM_IDLE      = 4'b0001,
    SM_RD_ADDR   = 4'b0010,
    SM_WAIT_DATA = 4'b0100,
    SM_RD_DONE   = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        rd_resp_q, rd_resp_d;
  logic              rd_timeout_d;
  logic              rd_timeout_s;
  logic              timeout_hit_s;

`ifdef AXI4_LITE_RD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_timeout_q;

  // Timeout counter next value: runs only while the slave owes us a handshake.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    if ((state_q == SM_RD_ADDR) || (state_q == SM_WAIT_DATA)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Timeout counter and timeout flag registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q        <= {CNT_W{1'b0}};
      rd_timeout_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end

  assign timeout_hit_s = (cnt_q == CNT_LAST);
  assign rd_timeout_s  = rd_timeout_q;
`else
  logic unused_timeout_s;

  assign timeout_hit_s    = 1'b0;
  assign rd_timeout_s     = 1'b0;
  assign unused_timeout_s = rd_timeout_d ^ (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and captured-data logic.
  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    rd_data_d    = rd_data_q;
    rd_resp_d    = rd_resp_q;
    rd_timeout_d = rd_timeout_s;
    case (state_q)
      SM_IDLE: begin
        if (rd_valid) begin
          araddr_d = rd_addr;
          state_d  = SM_RD_ADDR;
        end else begin
          state_d  = SM_IDLE;
        end
      end
      SM_RD_ADDR: begin
        // A handshake on the terminal count wins over the abort.
        if (s_axi.s_axi_arready) begin
          state_d = SM_WAIT_DATA;
        end else if (timeout_hit_s) begin
          rd_data_d    = {DATA_W{1'b0}};
          rd_resp_d    = 2'b10;
          rd_timeout_d = 1'b1;
          state_d      = SM_RD_DONE;
        end else begin
          state_d = SM_RD_ADDR;
        end
      end
      SM_WAIT_DATA: begin
        if (s_axi.s_axi_rvalid) begin
          rd_data_d    = s_axi.s_axi_rdata;
          rd_resp_d    = s_axi.s_axi_rresp;
          rd_timeout_d = 1'b0;
          state_d      = SM_RD_DONE;
        end else if (timeout_hit_s) begin
          rd_data_d    = {DATA_W{1'b0}};
          rd_resp_d    = 2'b10;
          rd_timeout_d = 1'b1;
          state_d      = SM_RD_DONE;
        end else begin
          state_d = SM_WAIT_DATA;
        end
      end
      SM_RD_DONE: begin
        if (rd_dready) begin
          state_d = SM_IDLE;
        end else begin
          state_d = SM_RD_DONE;
        end
      end
      default: begin
        state_d = SM_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= SM_IDLE;
      araddr_q  <= {ADDR_W{1'b0}};
      rd_data_q <= {DATA_W{1'b0}};
      rd_resp_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      rd_data_q <= rd_data_d;
      rd_resp_q <= rd_resp_d;
    end
  end

  // Every handshake output is a decode of the one-hot state register.
  assign rd_ready            = (state_q == SM_IDLE);
  assign rd_dvalid           = (state_q == SM_RD_DONE);
  assign rd_data             = rd_data_q;
  assign rd_resp             = rd_resp_q;
  assign rd_timeout          = rd_timeout_s;
  assign s_axi.s_axi_araddr  = araddr_q;
  assign s_axi.s_axi_arprot  = 3'b000;
  assign s_axi.s_axi_arvalid = (state_q == SM_RD_ADDR);
  assign s_axi.s_axi_rready  = (state_q == SM_WAIT_DATA);

endmodule

// File: tb/tb_axi4_lite_rd.sv
// Directed bench for axi4_lite_rd; the bench itself plays the AXI4-Lite slave and the user.
module tb_axi4_lite_rd;

  logic        clk;
  logic        arst_n;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_timeout;
  logic        rd_dvalid;
  logic        rd_dready;

  int n_tests = 0;
  int n_fail  = 0;

  axi4_lite_rd_if #(.ADDR_W(32), .DATA_W(32)) axi_if ();

  axi4_lite_rd #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_resp   (rd_resp),
    .rd_timeout(rd_timeout),
    .rd_dvalid (rd_dvalid),
    .rd_dready (rd_dready),
    .s_axi     (axi_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_ready"}, 32'(rd_ready), 32'd1);
    chk({tag, "_arvalid"},  32'(axi_if.s_axi_arvalid), 32'd0);
    chk({tag, "_rready"},   32'(axi_if.s_axi_rready), 32'd0);
    chk({tag, "_dvalid"},   32'(rd_dvalid), 32'd0);
    chk({tag, "_timeout"},  32'(rd_timeout), 32'd0);
    chk({tag, "_rd_data"},  rd_data, 32'd0);
    chk({tag, "_rd_resp"},  32'(rd_resp), 32'd0);
    chk({tag, "_araddr"},   axi_if.s_axi_araddr, 32'd0);
    chk({tag, "_arprot"},   32'(axi_if.s_axi_arprot), 32'd0);
  endtask

  // Full read: the slave answers after ar_dly / r_dly stall cycles, the user after dr_dly.
  // With r_dly == 0 rvalid rises together with arready and must not be taken early.
  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input int dr_dly, input logic [31:0] data, input logic [1:0] resp);
    rd_addr  = addr;
    rd_valid = 1'b1;
    chk("idle_rd_ready", 32'(rd_ready), 32'd1);
    step();
    rd_valid = 1'b0;
    rd_addr  = ~addr;
    for (int i = 0; i < ar_dly; i++) begin
      chk("ar_wait_arvalid", 32'(axi_if.s_axi_arvalid), 32'd1);
      chk("ar_wait_araddr",  axi_if.s_axi_araddr, addr);
      chk("ar_wait_rready",  32'(axi_if.s_axi_rready), 32'd0);
      step();
    end
    axi_if.s_axi_arready = 1'b1;
    if (r_dly == 0) begin
      axi_if.s_axi_rvalid = 1'b1;
      axi_if.s_axi_rdata  = data;
      axi_if.s_axi_rresp  = resp;
    end
    chk("ar_hs_arvalid",  32'(axi_if.s_axi_arvalid), 32'd1);
    chk("ar_hs_araddr",   axi_if.s_axi_araddr, addr);
    chk("ar_hs_rready",   32'(axi_if.s_axi_rready), 32'd0);
    chk("ar_hs_rd_ready", 32'(rd_ready), 32'd0);
    step();
    axi_if.s_axi_arready = 1'b0;
    chk("r_wait_arvalid", 32'(axi_if.s_axi_arvalid), 32'd0);
    chk("r_wait_dvalid",  32'(rd_dvalid), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      chk("r_wait_rready", 32'(axi_if.s_axi_rready), 32'd1);
      step();
    end
    axi_if.s_axi_rvalid = 1'b1;
    axi_if.s_axi_rdata  = data;
    axi_if.s_axi_rresp  = resp;
    chk("r_hs_rready", 32'(axi_if.s_axi_rready), 32'd1);
    step();
    axi_if.s_axi_rvalid = 1'b0;
    axi_if.s_axi_rdata  = ~data;
    axi_if.s_axi_rresp  = ~resp;
    rd_dready = 1'b0;
    for (int i = 0; i <= dr_dly; i++) begin
      if (i == dr_dly) rd_dready = 1'b1;
      chk("done_dvalid",   32'(rd_dvalid), 32'd1);
      chk("done_rd_data",  rd_data, data);
      chk("done_rd_resp",  32'(rd_resp), 32'(resp));
      chk("done_timeout",  32'(rd_timeout), 32'd0);
      chk("done_rd_ready", 32'(rd_ready), 32'd0);
      chk("done_rready",   32'(axi_if.s_axi_rready), 32'd0);
      step();
    end
    rd_dready = 1'b0;
    chk("post_dvalid",   32'(rd_dvalid), 32'd0);
    chk("post_rd_ready", 32'(rd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    arst_n               = 1'b0;
    rd_addr              = 32'h0;
    rd_valid             = 1'b0;
    rd_dready            = 1'b0;
    axi_if.s_axi_arready = 1'b0;
    axi_if.s_axi_rvalid  = 1'b0;
    axi_if.s_axi_rdata   = 32'h0;
    axi_if.s_axi_rresp   = 2'b00;
    step();
    step();
    chk_reset_vals("reset");
    arst_n = 1'b1;
    step();
    chk_reset_vals("after_release");

    // Minimum-latency read with rvalid raised during the AR handshake.
    do_read(32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);

    // Slow slave: arready after 5 cycles, rvalid after 7.
    do_read(32'h0000_0A04, 5, 7, 0, 32'hCAFE_F00D, 2'b01);

    // DECERR passed through, user stalls 4 cycles.
    do_read(32'h0000_0020, 0, 1, 4, 32'h1234_5678, 2'b11);
    do_read(32'h0000_0024, 0, 0, 0, 32'h0BAD_C0DE, 2'b10);

    // Back-to-back reads with random stalls.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      r = 2'($urandom_range(0, 3));
      do_read(32'h0000_1000 + 32'(i * 4), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), d, r);
    end

    // Reset asserted while waiting for R data.
    rd_addr  = 32'h0000_0040;
    rd_valid = 1'b1;
    step();
    rd_valid             = 1'b0;
    axi_if.s_axi_arready = 1'b1;
    step();
    axi_if.s_axi_arready = 1'b0;
    chk("mid_rready", 32'(axi_if.s_axi_rready), 32'd1);
    arst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    chk_reset_vals("rst_edge");
    arst_n = 1'b1;
    step();
    chk("rst_recover_rd_ready", 32'(rd_ready), 32'd1);

    // Slave never answers AR.
    rd_addr  = 32'h0000_0080;
    rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_arvalid", 32'(axi_if.s_axi_arvalid), 32'd1);
      chk("to_wait_dvalid",  32'(rd_dvalid), 32'd0);
      step();
    end
`ifdef AXI4_LITE_RD_TIMEOUT_EN
    chk("to_dvalid",  32'(rd_dvalid), 32'd1);
    chk("to_timeout", 32'(rd_timeout), 32'd1);
    chk("to_resp",    32'(rd_resp), 32'd2);
    chk("to_data",    rd_data, 32'd0);
    chk("to_arvalid", 32'(axi_if.s_axi_arvalid), 32'd0);
    rd_dready = 1'b1;
    step();
    rd_dready = 1'b0;
    chk("to_post_rd_ready", 32'(rd_ready), 32'd1);
    chk("to_post_dvalid",   32'(rd_dvalid), 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      chk("noto_arvalid", 32'(axi_if.s_axi_arvalid), 32'd1);
      chk("noto_dvalid",  32'(rd_dvalid), 32'd0);
      chk("noto_timeout", 32'(rd_timeout), 32'd0);
      step();
    end
    axi_if.s_axi_arready = 1'b1;
    step();
    axi_if.s_axi_arready = 1'b0;
    axi_if.s_axi_rvalid  = 1'b1;
    axi_if.s_axi_rdata   = 32'h5555_AAAA;
    axi_if.s_axi_rresp   = 2'b00;
    step();
    axi_if.s_axi_rvalid = 1'b0;
    chk("noto_late_dvalid", 32'(rd_dvalid), 32'd1);
    chk("noto_late_data",   rd_data, 32'h5555_AAAA);
    rd_dready = 1'b1;
    step();
    rd_dready = 1'b0;
    chk("noto_post_rd_ready", 32'(rd_ready), 32'd1);
`endif

    // One more normal read proves recovery.
    do_read(32'h0000_00F0, 1, 2, 1, 32'hA5A5_5A5A, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
